// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_stage_pkg : shared FSM state type and constants for the MEM stage     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mem_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT_RD = 2'd2
  } mem_state_t;

  localparam logic [3:0] BE_WORD = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_lane_align : byte-lane steering for stores and load data extraction   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic        byte_access,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic [31:0] load_data
);

  logic [31:0] w_lane_shift;

  always_comb begin
    w_lane_shift = rdata >> {addr[1:0], 3'b000};
    if (byte_access) begin
      mem_addr  = addr;
      mem_wdata = {4{store_data[7:0]}};
      mem_be    = 4'b0001 << addr[1:0];
      load_data = {24'h0, w_lane_shift[7:0]};
    end else begin
      mem_addr  = {addr[31:2], 2'b00};
      mem_wdata = store_data;
      mem_be    = BE_WORD;
      load_data = rdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_stage : MEM pipeline stage with req/gnt/rvalid data interface  |
// | Optional access timeout: define MEM_ACCESS_TIMEOUT_EN.  Rev 1.0          |
// +--------------------------------------------------------------------------+
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_in,
  input  logic        ex_mem_read_in,
  input  logic        ex_mem_write_in,
  input  logic        ex_byte_in,
  input  logic [31:0] ex_alu_result_in,
  input  logic [31:0] ex_store_data_in,
  input  logic [3:0]  ex_rd_in,
  input  logic        reg_write_enable_in,
  input  logic        mem_to_reg_select_in,
  output logic        mem_stall_out,
  output logic        dmem_req_out,
  output logic        dmem_we_out,
  output logic [31:0] dmem_addr_out,
  output logic [31:0] dmem_wdata_out,
  output logic [3:0]  dmem_be_out,
  input  logic        dmem_gnt_in,
  input  logic        dmem_rvalid_in,
  input  logic [31:0] dmem_rdata_in,
  output logic        wb_valid_out,
  output logic        reg_write_enable_out,
  output logic        mem_to_reg_select_out,
  output logic [3:0]  wb_rd_out,
  output logic [31:0] wb_alu_result_out,
  output logic [31:0] wb_load_data_out,
  output logic        mem_fault_out
);

  mem_state_t  r_state, w_state_next;
  logic [31:0] r_addr, r_store_data;
  logic [3:0]  r_rd;
  logic        r_byte, r_store, r_rwe, r_m2r;

  logic        r_wb_valid, r_wb_rwe, r_wb_m2r;
  logic [3:0]  r_wb_rd;
  logic [31:0] r_wb_alu, r_wb_load;

  logic        w_accept_alu, w_accept_mem, w_done_store, w_done_load, w_abort;
  logic        w_expired, w_in_req;
  logic [31:0] w_mem_addr, w_mem_wdata, w_load_data;
  logic [3:0]  w_mem_be;

  mem_lane_align u_lane_align (
    .byte_access (r_byte),
    .addr        (r_addr),
    .store_data  (r_store_data),
    .rdata       (dmem_rdata_in),
    .mem_addr    (w_mem_addr),
    .mem_wdata   (w_mem_wdata),
    .mem_be      (w_mem_be),
    .load_data   (w_load_data)
  );

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int                c_tcnt_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tcnt_w-1:0] c_tcnt_last = c_tcnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_tcnt_w-1:0] r_tcnt;
  logic                r_fault;

  // Counts busy cycles; the TIMEOUT_CYCLES-th busy cycle without a response aborts.
  always_ff @(posedge clk) begin
    if (reset || r_state == S_IDLE) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + c_tcnt_w'(1);
    end
    r_fault <= reset ? 1'b0 : w_abort;
  end

  assign w_expired     = (r_tcnt == c_tcnt_last);
  assign mem_fault_out = r_fault;
`else
  assign w_expired     = 1'b0;
  assign mem_fault_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept_alu = 1'b0;
    w_accept_mem = 1'b0;
    w_done_store = 1'b0;
    w_done_load  = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ex_valid_in) begin
          if (ex_mem_read_in || ex_mem_write_in) begin
            w_accept_mem = 1'b1;
            w_state_next = S_REQ;
          end else begin
            w_accept_alu = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_in) begin
          if (r_store) begin
            w_done_store = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_WAIT_RD;
          end
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_WAIT_RD: begin
        if (dmem_rvalid_in) begin
          w_done_load  = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_expired) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_store_data <= '0;
      r_rd         <= '0;
      r_byte       <= 1'b0;
      r_store      <= 1'b0;
      r_rwe        <= 1'b0;
      r_m2r        <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_rwe     <= 1'b0;
      r_wb_m2r     <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_alu     <= '0;
      r_wb_load    <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_wb_rwe   <= 1'b0;
      r_wb_m2r   <= 1'b0;
      if (w_accept_alu) begin
        r_wb_valid <= 1'b1;
        r_wb_rwe   <= reg_write_enable_in;
        r_wb_m2r   <= mem_to_reg_select_in;
        r_wb_rd    <= ex_rd_in;
        r_wb_alu   <= ex_alu_result_in;
      end
      if (w_accept_mem) begin
        r_addr       <= ex_alu_result_in;
        r_store_data <= ex_store_data_in;
        r_rd         <= ex_rd_in;
        r_byte       <= ex_byte_in;
        r_store      <= ex_mem_write_in;
        r_rwe        <= reg_write_enable_in;
        r_m2r        <= mem_to_reg_select_in;
      end
      if (w_done_store || w_done_load) begin
        r_wb_valid <= 1'b1;
        r_wb_rwe   <= r_rwe;
        r_wb_m2r   <= r_m2r;
        r_wb_rd    <= r_rd;
        r_wb_alu   <= r_addr;
      end
      if (w_done_load) begin
        r_wb_load <= w_load_data;
      end
      // An aborted access retires without writing the register file.
      if (w_abort) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_alu   <= r_addr;
      end
    end
  end

  assign w_in_req       = (r_state == S_REQ);
  assign mem_stall_out  = (r_state != S_IDLE);
  assign dmem_req_out   = w_in_req;
  assign dmem_we_out    = w_in_req & r_store;
  assign dmem_addr_out  = w_in_req ? w_mem_addr  : 32'h0;
  assign dmem_wdata_out = w_in_req ? w_mem_wdata : 32'h0;
  assign dmem_be_out    = w_in_req ? w_mem_be    : BE_NONE;

  assign wb_valid_out          = r_wb_valid;
  assign reg_write_enable_out  = r_wb_rwe;
  assign mem_to_reg_select_out = r_wb_m2r;
  assign wb_rd_out             = r_wb_rd;
  assign wb_alu_result_out     = r_wb_alu;
  assign wb_load_data_out      = r_wb_load;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_stage : directed scenarios plus random traffic vs. a        |
// | transaction-level model.  Rev 1.0                                        |
// +--------------------------------------------------------------------------+
module tb_mem_access_stage;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
  localparam int GNT_MAX    = 1;
  localparam int RV_MAX     = 0;
`else
  localparam int TB_TIMEOUT = 16;
  localparam int GNT_MAX    = 3;
  localparam int RV_MAX     = 3;
`endif

  typedef struct packed {
    logic        rd_op;
    logic        wr_op;
    logic        byte_op;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [3:0]  rd;
    logic        rwe;
    logic        m2r;
  } instr_t;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] alu;
    logic        rwe;
    logic        m2r;
    logic        is_load;
    logic [31:0] ld;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_in, ex_mem_read_in, ex_mem_write_in, ex_byte_in;
  logic [31:0] ex_alu_result_in, ex_store_data_in;
  logic [3:0]  ex_rd_in;
  logic        reg_write_enable_in, mem_to_reg_select_in;
  logic        mem_stall_out, dmem_req_out, dmem_we_out;
  logic [31:0] dmem_addr_out, dmem_wdata_out;
  logic [3:0]  dmem_be_out;
  logic        dmem_gnt_in, dmem_rvalid_in;
  logic [31:0] dmem_rdata_in;
  logic        wb_valid_out, reg_write_enable_out, mem_to_reg_select_out;
  logic [3:0]  wb_rd_out;
  logic [31:0] wb_alu_result_out, wb_load_data_out;
  logic        mem_fault_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [142:0] all_out;
  assign all_out = {mem_stall_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_wdata_out,
                    dmem_be_out, wb_valid_out, reg_write_enable_out, mem_to_reg_select_out,
                    wb_rd_out, wb_alu_result_out, wb_load_data_out, mem_fault_out};

  mem_access_stage #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ex_valid_in           (ex_valid_in),
    .ex_mem_read_in        (ex_mem_read_in),
    .ex_mem_write_in       (ex_mem_write_in),
    .ex_byte_in            (ex_byte_in),
    .ex_alu_result_in      (ex_alu_result_in),
    .ex_store_data_in      (ex_store_data_in),
    .ex_rd_in              (ex_rd_in),
    .reg_write_enable_in   (reg_write_enable_in),
    .mem_to_reg_select_in  (mem_to_reg_select_in),
    .mem_stall_out         (mem_stall_out),
    .dmem_req_out          (dmem_req_out),
    .dmem_we_out           (dmem_we_out),
    .dmem_addr_out         (dmem_addr_out),
    .dmem_wdata_out        (dmem_wdata_out),
    .dmem_be_out           (dmem_be_out),
    .dmem_gnt_in           (dmem_gnt_in),
    .dmem_rvalid_in        (dmem_rvalid_in),
    .dmem_rdata_in         (dmem_rdata_in),
    .wb_valid_out          (wb_valid_out),
    .reg_write_enable_out  (reg_write_enable_out),
    .mem_to_reg_select_out (mem_to_reg_select_out),
    .wb_rd_out             (wb_rd_out),
    .wb_alu_result_out     (wb_alu_result_out),
    .wb_load_data_out      (wb_load_data_out),
    .mem_fault_out         (mem_fault_out)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    ex_valid_in = 0; ex_mem_read_in = 0; ex_mem_write_in = 0; ex_byte_in = 0;
    ex_alu_result_in = 0; ex_store_data_in = 0; ex_rd_in = 0;
    reg_write_enable_in = 0; mem_to_reg_select_in = 0;
    dmem_gnt_in = 0; dmem_rvalid_in = 0; dmem_rdata_in = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if ({mem_stall_out, wb_valid_out} !== 2'b00) begin
      n_bad++; $display("FAIL reset_release_idle: stall/valid %b required 00", {mem_stall_out, wb_valid_out});
    end
  endtask

  task automatic test_alu_op();
    ex_valid_in = 1; ex_rd_in = 4'd5; ex_alu_result_in = 32'h1234;
    reg_write_enable_in = 1; mem_to_reg_select_in = 0; ex_byte_in = 1'($urandom);
    n_cmp++;
    if (mem_stall_out !== 1'b0) begin
      n_bad++; $display("FAIL alu_stall_n: got %b required 0", mem_stall_out);
    end
    @(negedge clk);
    ex_valid_in = 0;
    n_cmp++;
    if ({wb_valid_out, wb_rd_out, wb_alu_result_out, reg_write_enable_out, mem_to_reg_select_out, mem_stall_out}
        !== {1'b1, 4'd5, 32'h1234, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL alu_wb_n1: valid=%b rd=%0d alu=%h rwe=%b m2r=%b stall=%b required 1/5/1234/1/0/0",
                        wb_valid_out, wb_rd_out, wb_alu_result_out, reg_write_enable_out,
                        mem_to_reg_select_out, mem_stall_out);
    end
    @(negedge clk);
    n_cmp++;
    if ({wb_valid_out, reg_write_enable_out, mem_to_reg_select_out} !== 3'b000) begin
      n_bad++; $display("FAIL alu_pulse_end: got %b required 000",
                        {wb_valid_out, reg_write_enable_out, mem_to_reg_select_out});
    end
  endtask

  task automatic test_byte_store();
    int n_stall;
    n_stall = 0;
    ex_valid_in = 1; ex_mem_write_in = 1; ex_mem_read_in = 0; ex_byte_in = 1;
    ex_alu_result_in = 32'h102; ex_store_data_in = 32'h5A5A_55AB; ex_rd_in = 4'd2;
    reg_write_enable_in = 0; mem_to_reg_select_in = 0;
    @(negedge clk);
    ex_valid_in = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_stall_out === 1'b1) n_stall++;
      n_cmp++;
      if ({dmem_req_out, dmem_we_out, dmem_be_out, dmem_wdata_out} !== {1'b1, 1'b1, 4'b0100, 32'hABABABAB}) begin
        n_bad++; $display("FAIL bstore_req_c%0d: req=%b we=%b be=%b wdata=%h required 1/1/0100/abababab",
                          i, dmem_req_out, dmem_we_out, dmem_be_out, dmem_wdata_out);
      end
      dmem_gnt_in = (i == 3);
      @(negedge clk);
    end
    dmem_gnt_in = 0;
    n_cmp++;
    if (n_stall != 4 || mem_stall_out !== 1'b0) begin
      n_bad++; $display("FAIL bstore_stall_cycles: got %0d (stall now %b) required 4 (0)", n_stall, mem_stall_out);
    end
    n_cmp++;
    if ({wb_valid_out, wb_rd_out, wb_alu_result_out} !== {1'b1, 4'd2, 32'h102}) begin
      n_bad++; $display("FAIL bstore_wb: valid=%b rd=%0d alu=%h required 1/2/102",
                        wb_valid_out, wb_rd_out, wb_alu_result_out);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_word_load();
    ex_valid_in = 1; ex_mem_read_in = 1; ex_mem_write_in = 0; ex_byte_in = 0;
    ex_alu_result_in = 32'h203; ex_rd_in = 4'd3; reg_write_enable_in = 1; mem_to_reg_select_in = 1;
    @(negedge clk);
    ex_valid_in = 0;
    n_cmp++;
    if ({mem_stall_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out} !== {3'b110, 32'h200, 4'hF}) begin
      n_bad++; $display("FAIL wload_req: stall=%b req=%b we=%b addr=%h be=%h required 1/1/0/200/f",
                        mem_stall_out, dmem_req_out, dmem_we_out, dmem_addr_out, dmem_be_out);
    end
    dmem_gnt_in = 1;
    @(negedge clk);
    dmem_gnt_in = 0;
    n_cmp++;
    if ({mem_stall_out, dmem_req_out} !== 2'b10) begin
      n_bad++; $display("FAIL wload_wait: stall/req %b required 10", {mem_stall_out, dmem_req_out});
    end
    dmem_rvalid_in = 1; dmem_rdata_in = 32'hDEADBEEF;
    @(negedge clk);
    dmem_rvalid_in = 0; dmem_rdata_in = 0;
    n_cmp++;
    if ({wb_valid_out, wb_load_data_out, mem_to_reg_select_out, reg_write_enable_out, wb_rd_out, mem_stall_out}
        !== {1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 4'd3, 1'b0}) begin
      n_bad++; $display("FAIL wload_wb: valid=%b ld=%h m2r=%b rwe=%b rd=%0d stall=%b required 1/deadbeef/1/1/3/0",
                        wb_valid_out, wb_load_data_out, mem_to_reg_select_out, reg_write_enable_out,
                        wb_rd_out, mem_stall_out);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid_access();
    ex_valid_in = 1; ex_mem_read_in = 1; ex_byte_in = 0; ex_alu_result_in = 32'h0000_0340;
    ex_rd_in = 4'd7; reg_write_enable_in = 1; mem_to_reg_select_in = 1;
    @(negedge clk);
    ex_valid_in = 0; dmem_gnt_in = 1;
    @(negedge clk);
    dmem_gnt_in = 0;
    n_cmp++;
    if ({mem_stall_out, dmem_req_out} !== 2'b10) begin
      n_bad++; $display("FAIL rstmid_in_wait: stall/req %b required 10", {mem_stall_out, dmem_req_out});
    end
    reset = 1;
    @(negedge clk);
    reset = 0; dmem_rvalid_in = 1; dmem_rdata_in = 32'hCAFE_F00D;
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got %h required 0", all_out);
    end
    @(negedge clk);
    dmem_rvalid_in = 0;
    n_cmp++;
    if ({wb_valid_out, mem_stall_out, reg_write_enable_out} !== 3'b000) begin
      n_bad++; $display("FAIL rstmid_rvalid_ignored: valid/stall/rwe %b required 000",
                        {wb_valid_out, mem_stall_out, reg_write_enable_out});
    end
    ex_valid_in = 1; ex_mem_read_in = 0; ex_rd_in = 4'd9; ex_alu_result_in = 32'h0BAD_0009;
    reg_write_enable_in = 1; mem_to_reg_select_in = 0;
    @(negedge clk);
    ex_valid_in = 0;
    n_cmp++;
    if ({wb_valid_out, wb_rd_out, wb_alu_result_out} !== {1'b1, 4'd9, 32'h0BAD_0009}) begin
      n_bad++; $display("FAIL rstmid_next_accept: valid=%b rd=%0d alu=%h required 1/9/0bad0009",
                        wb_valid_out, wb_rd_out, wb_alu_result_out);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_random(input int n_instr);
    exp_t   exp_q[$];
    exp_t   e;
    instr_t cur, op;
    bit     held, mbusy, granted, busy_now;
    int     issued, gnt_wait, gnt_delay, rv_cnt, budget;
    logic [68:0] req_exp;
    held = 0; mbusy = 0; granted = 0; issued = 0;
    gnt_wait = 0; gnt_delay = 0; rv_cnt = 0;
    cur = '0; op = '0;
    budget = n_instr * 16 + 100;
    while ((issued < n_instr || held || mbusy || exp_q.size() != 0) && budget > 0) begin
      budget--;
      n_cmp++;
      if (mem_stall_out !== mbusy) begin
        n_bad++; $display("FAIL rand_stall: got %b required %b (t=%0t)", mem_stall_out, mbusy, $time);
      end
      n_cmp++;
      if (dmem_req_out !== (mbusy && !granted)) begin
        n_bad++; $display("FAIL rand_req: got %b required %b (t=%0t)", dmem_req_out, mbusy && !granted, $time);
      end
      if (mbusy && !granted) begin
        req_exp[68]    = op.wr_op;
        req_exp[67:36] = op.byte_op ? op.alu : (op.alu & ~32'h3);
        req_exp[35:4]  = op.byte_op ? (32'h01010101 * {24'h0, op.sd[7:0]}) : op.sd;
        req_exp[3:0]   = op.byte_op ? 4'(1 << (op.alu % 4)) : 4'hF;
        n_cmp++;
        if ({dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out} !== req_exp) begin
          n_bad++; $display("FAIL rand_req_fields: we/addr/wdata/be got %h required %h (t=%0t)",
                            {dmem_we_out, dmem_addr_out, dmem_wdata_out, dmem_be_out}, req_exp, $time);
        end
      end
      if (wb_valid_out === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_wb_unexpected: valid=1 with nothing outstanding (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          if ({wb_rd_out, wb_alu_result_out, reg_write_enable_out, mem_to_reg_select_out}
              !== {e.rd, e.alu, e.rwe, e.m2r} ||
              (e.is_load && wb_load_data_out !== e.ld)) begin
            n_bad++; $display("FAIL rand_wb: rd=%0d alu=%h rwe=%b m2r=%b ld=%h required %0d/%h/%b/%b/%h (t=%0t)",
                              wb_rd_out, wb_alu_result_out, reg_write_enable_out, mem_to_reg_select_out,
                              wb_load_data_out, e.rd, e.alu, e.rwe, e.m2r, e.ld, $time);
          end
        end
      end else begin
        n_cmp++;
        if ({reg_write_enable_out, mem_to_reg_select_out} !== 2'b00) begin
          n_bad++; $display("FAIL rand_ctrl_idle: rwe/m2r %b required 00 (t=%0t)",
                            {reg_write_enable_out, mem_to_reg_select_out}, $time);
        end
      end

      busy_now = mbusy;
      dmem_gnt_in = 0; dmem_rvalid_in = 0; dmem_rdata_in = $urandom;
      if (mbusy && !granted) begin
        dmem_rvalid_in = ($urandom_range(3, 0) == 0);
        if (gnt_wait == gnt_delay) begin
          dmem_gnt_in = 1;
          if (op.wr_op) begin
            exp_q.push_back('{rd: op.rd, alu: op.alu, rwe: op.rwe, m2r: op.m2r, is_load: 1'b0, ld: 32'h0});
            mbusy = 0;
          end else begin
            granted = 1;
            rv_cnt  = $urandom_range(RV_MAX, 0);
          end
        end else begin
          gnt_wait++;
        end
      end else if (mbusy) begin
        if (rv_cnt == 0) begin
          dmem_rvalid_in = 1;
          e = '{rd: op.rd, alu: op.alu, rwe: op.rwe, m2r: op.m2r, is_load: 1'b1, ld: 32'h0};
          e.ld = op.byte_op ? ((dmem_rdata_in >> (8 * (op.alu % 4))) & 32'hFF) : dmem_rdata_in;
          exp_q.push_back(e);
          mbusy = 0; granted = 0;
        end else begin
          rv_cnt--;
        end
      end else begin
        dmem_gnt_in    = ($urandom_range(3, 0) == 0);
        dmem_rvalid_in = ($urandom_range(3, 0) == 0);
      end

      if (!held && issued < n_instr && $urandom_range(4, 0) != 0) begin
        cur.alu = $urandom; cur.sd = $urandom; cur.rd = 4'($urandom);
        cur.rwe = 1'($urandom); cur.m2r = 1'($urandom); cur.byte_op = 1'($urandom);
        case ($urandom_range(4, 0))
          0, 1:    begin cur.rd_op = 0; cur.wr_op = 0; end
          2:       begin cur.rd_op = 1; cur.wr_op = 0; end
          3:       begin cur.rd_op = 0; cur.wr_op = 1; end
          default: begin cur.rd_op = 1; cur.wr_op = 1; end
        endcase
        held = 1;
      end
      ex_valid_in = held; ex_mem_read_in = cur.rd_op; ex_mem_write_in = cur.wr_op;
      ex_byte_in = cur.byte_op; ex_alu_result_in = cur.alu; ex_store_data_in = cur.sd;
      ex_rd_in = cur.rd; reg_write_enable_in = cur.rwe; mem_to_reg_select_in = cur.m2r;
      if (held && !busy_now) begin
        held = 0;
        issued++;
        if (cur.rd_op || cur.wr_op) begin
          op = cur; mbusy = 1; granted = 0; gnt_wait = 0;
          gnt_delay = $urandom_range(GNT_MAX, 0);
        end else begin
          exp_q.push_back('{rd: cur.rd, alu: cur.alu, rwe: cur.rwe, m2r: cur.m2r, is_load: 1'b0, ld: 32'h0});
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0 || held || mbusy || issued != n_instr) begin
      n_bad++; $display("FAIL rand_drain: issued=%0d of %0d, %0d results outstanding, busy=%b",
                        issued, n_instr, exp_q.size(), mbusy);
    end
    clear_inputs();
    @(negedge clk);
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    int  n_stall;
    bit  seen;
    n_stall = 0; seen = 0;
    ex_valid_in = 1; ex_mem_write_in = 1; ex_byte_in = 0; ex_alu_result_in = 32'h400;
    ex_rd_in = 4'd4; reg_write_enable_in = 1; mem_to_reg_select_in = 0;
    @(negedge clk);
    ex_valid_in = 0;
    for (int i = 0; i < TB_TIMEOUT + 6 && !seen; i++) begin
      if (wb_valid_out === 1'b1) begin
        seen = 1;
        n_cmp++;
        if ({mem_fault_out, reg_write_enable_out, mem_stall_out} !== 3'b100 || n_stall != TB_TIMEOUT) begin
          n_bad++; $display("FAIL timeout_abort: fault/rwe/stall %b after %0d stall cycles required 100 after %0d",
                            {mem_fault_out, reg_write_enable_out, mem_stall_out}, n_stall, TB_TIMEOUT);
        end
      end else begin
        if (mem_stall_out === 1'b1) n_stall++;
        @(negedge clk);
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL timeout_never_fired: no wb_valid within %0d cycles", TB_TIMEOUT + 6);
    end
    @(negedge clk);
    n_cmp++;
    if ({mem_fault_out, wb_valid_out, mem_stall_out} !== 3'b000) begin
      n_bad++; $display("FAIL timeout_pulse_end: fault/valid/stall %b required 000",
                        {mem_fault_out, wb_valid_out, mem_stall_out});
    end
    clear_inputs();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_alu_op();
    test_byte_store();
    test_word_load();
    test_reset_mid_access();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    test_random(300);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the cycles an access may sit in REQ/WAIT_RD before abort when the timeout is compiled in.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 ex_valid_in  input  1  SHALL mean the EX/MEM-side instruction is valid.
REQ-005 ex_mem_read_in  input  1  SHALL mark a load.
REQ-006 ex_mem_write_in  input  1  SHALL mark a store.
REQ-007 ex_byte_in  input  1  SHALL select byte access (0 = word).
REQ-008 ex_alu_result_in  input  32  SHALL carry the ALU result, which is also the memory address.
REQ-009 ex_store_data_in  input  32  SHALL carry the store data.
REQ-010 ex_rd_in  input  4  SHALL carry the destination register index.
REQ-011 reg_write_enable_in  input  1  SHALL carry the register write enable control.
REQ-012 mem_to_reg_select_in  input  1  SHALL carry the memory-to-register select control.
REQ-013 mem_stall_out  output  1  SHALL tell upstream to hold its current instruction.
REQ-014 dmem_req_out  output  1  SHALL carry the data-memory request.
REQ-015 dmem_we_out  output  1  SHALL carry the write enable (1 = store).
REQ-016 dmem_addr_out  output  32  SHALL carry the access address.
REQ-017 dmem_wdata_out  output  32  SHALL carry the write data.
REQ-018 dmem_be_out  output  4  SHALL carry the byte-lane enables.
REQ-019 dmem_gnt_in  input  1  SHALL mean memory accepts the request this cycle.
REQ-020 dmem_rvalid_in  input  1  SHALL mean read data is valid this cycle.
REQ-021 dmem_rdata_in  input  32  SHALL carry the read data.
REQ-022 wb_valid_out  output  1  SHALL mean a completed instruction is presented to MEM/WB.
REQ-023 reg_write_enable_out  output  1  SHALL carry the register write enable to MEM/WB.
REQ-024 mem_to_reg_select_out  output  1  SHALL carry the memory-to-register select to MEM/WB.
REQ-025 wb_rd_out  output  4  SHALL carry the destination register index.
REQ-026 wb_alu_result_out  output  32  SHALL carry the registered ALU result.
REQ-027 wb_load_data_out  output  32  SHALL carry the aligned load data.
REQ-028 mem_fault_out  output  1  SHALL pulse on access timeout.

Function
REQ-029 FSM SHALL have states IDLE, REQ, WAIT_RD; mem_stall_out = (state != IDLE), combinational.
REQ-030 IDLE with ex_valid_in=1 and no read/write SHALL register the instruction and show it with wb_valid_out=1 in cycle N+1, where N is the presentation cycle; no stall.
REQ-031 IDLE with a memory op SHALL capture all inputs and go to REQ; read=write=1 SHALL be treated as a store.
REQ-032 REQ SHALL drive dmem_req_out=1 with stable addr/we/wdata/be until dmem_gnt_in=1.
- Store with gnt: go to IDLE; wb_valid_out=1 next cycle.
- Load with gnt: go to WAIT_RD.
REQ-033 WAIT_RD SHALL hold dmem_req_out=0 and on dmem_rvalid_in=1 capture data, go to IDLE, and assert wb_valid_out=1 next cycle; rvalid outside WAIT_RD SHALL be ignored.
REQ-034 Minimum latency SHALL be: non-memory op valid at N+1; store at N+2; load at N+3.
REQ-035 Word access SHALL use dmem_be_out=4'hF and dmem_addr_out with bits [1:0] forced to 00.
REQ-036 Byte access SHALL use be = 1<<addr[1:0], wdata = store byte replicated to all four lanes, and load data = selected lane zero-extended.
REQ-037 wb_valid_out SHALL be a single-cycle pulse per instruction; while wb_valid_out=0, reg_write_enable_out and mem_to_reg_select_out SHALL be 0.

Reset
REQ-038 reset SHALL force IDLE, clear the timeout counter, and zero every output on the next edge; it overrides all other events, including a reset arriving mid-access, and SHALL drop dmem_req_out.
REQ-039 The first instruction after reset deasserts SHALL be accepted normally.

Configuration
REQ-040 With MEM_ACCESS_TIMEOUT_EN defined, a counter SHALL count cycles in REQ/WAIT_RD. On reaching TIMEOUT_CYCLES the block SHALL go to IDLE and, for one cycle, drive wb_valid_out=1, reg_write_enable_out=0 and mem_fault_out=1.
REQ-041 Without MEM_ACCESS_TIMEOUT_EN there SHALL be no counter, mem_fault_out SHALL be tied to 0, and the block SHALL wait indefinitely.

Structure
REQ-042 Package mem_stage_pkg SHALL hold the FSM state enum, the BE_WORD/BE_NONE constants and the default timeout constant.
REQ-043 Byte-lane steering SHALL live in one combinational sub-module, mem_lane_align.

Verification
REQ-044 ALU op, rd=5, result 0x1234 at cycle N -> wb_valid_out=1 at N+1, wb_alu_result_out=0x1234, no stall.
REQ-045 Byte store of data 0xAB to addr 0x102, gnt delayed 3 cycles -> be=4'b0100, wdata=0xABABABAB, stall for 4 cycles.
REQ-046 Word load from addr 0x203, gnt immediate, rdata=0xDEADBEEF two cycles later -> dmem_addr_out=0x200, wb_load_data_out=0xDEADBEEF, mem_to_reg_select_out=1.
REQ-047 reset in WAIT_RD, then rvalid -> all outputs 0, rvalid ignored, next instruction accepted.
REQ-048 MEM_ACCESS_TIMEOUT_EN with TIMEOUT_CYCLES=4 and gnt never asserted -> mem_fault_out pulses once, reg_write_enable_out=0, return to IDLE.
